// File: rtl/seg_share_arb_if.sv
// Request/data/grant/hex bundle between the application requesters (master)
// and the shared seven-segment arbiter (slave).
interface seg_share_arb_if;
  logic [3:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] data3;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;

  modport master (
    output req, data0, data1, data2, data3,
    input  gnt, busy, hex3, hex2, hex1, hex0
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output gnt, busy, hex3, hex2, hex1, hex0
  );
endinterface

// File: rtl/seg_share_arb.sv
// Round-robin owner arbiter for the shared 4-digit display, with minimum hold time.
// Optional macro SEG_ARB_PRIO_EN: a rising req[0] preempts any other owner.
module seg_share_arb #(
  parameter int              HOLD_CYC  = 8,
  parameter int              CNT_W     = 4,
  parameter logic [15:0]     IDLE_WORD = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  seg_share_arb_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_OPEN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);
  // With a one-cycle hold the first grant cycle already satisfies the minimum.
  localparam state_t GRANT_ST = (HOLD_CYC == 1) ? ST_OPEN : ST_HOLD;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [15:0]      hex_q, hex_d;

  logic [3:0] cand_mask;
  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_found;
  logic       owner_req;
  logic       do_grant;
  logic       do_idle;

  // The owner sits last in the search order, so masking it out leaves the others.
  always_comb begin
    cand_mask = bus.req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = last_q;
    scan_idx  = last_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_q + 2'(i);
      if (!win_found && cand_mask[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign owner_req = |(bus.req & gnt_q);

`ifdef SEG_ARB_PRIO_EN
  logic req0_q, req0_d;
  assign req0_d = bus.req[0];
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) do_grant = 1'b1;
      end
      ST_HOLD: begin
        if (!owner_req) begin
          do_grant = win_found;
          do_idle  = !win_found;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (!owner_req) begin
          do_grant = win_found;
          do_idle  = !win_found;
        end else if (win_found) begin
          do_grant = 1'b1;
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      gnt_d   = 4'b0001 << win_idx;
      last_d  = win_idx;
      cnt_d   = '0;
      state_d = GRANT_ST;
    end else if (do_idle) begin
      gnt_d   = 4'b0000;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end

`ifdef SEG_ARB_PRIO_EN
    if (state_q != ST_IDLE && !gnt_q[0] && bus.req[0] && !req0_q) begin
      gnt_d   = 4'b0001;
      last_d  = 2'd0;
      cnt_d   = '0;
      state_d = GRANT_ST;
    end
`endif
  end

  // The display follows whoever owned it last cycle; last_q is the owner while granted.
  always_comb begin
    hex_d = IDLE_WORD;
    if (gnt_q != 4'b0000) begin
      case (last_q)
        2'd0:    hex_d = bus.data0;
        2'd1:    hex_d = bus.data1;
        2'd2:    hex_d = bus.data2;
        default: hex_d = bus.data3;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      hex_q   <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      hex_q   <= hex_d;
    end
  end

`ifdef SEG_ARB_PRIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req0_q <= 1'b0;
    else       req0_q <= req0_d;
  end
`endif

  assign bus.gnt  = gnt_q;
  assign bus.busy = |gnt_q;
  assign {bus.hex3, bus.hex2, bus.hex1, bus.hex0} = hex_q;

endmodule

// File: tb/tb_seg_share_arb.sv
// Directed checks for seg_share_arb: reset, latency, rotation, release, async reset, preemption.
module tb_seg_share_arb;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  seg_share_arb_if bus ();

  seg_share_arb #(
    .HOLD_CYC  (8),
    .CNT_W     (4),
    .IDLE_WORD (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] hex_word();
    return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  logic [3:0]  exp_gnt;
  logic [15:0] exp_hex;
  logic [15:0] prev_data;

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    bus.req   = 4'b0000;
    bus.data0 = 16'h1111;
    bus.data1 = 16'h1234;
    bus.data2 = 16'h2222;
    bus.data3 = 16'h3333;

    // Reset values
    #2 reset = 1'b1;
    #1;
    check_val("rst_gnt", 16'(bus.gnt), 16'h0);
    check_val("rst_busy", 16'(bus.busy), 16'h0);
    check_val("rst_hex", hex_word(), 16'h0000);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check_val("idle_gnt", 16'(bus.gnt), 16'h0);
    check_val("idle_busy", 16'(bus.busy), 16'h0);
    check_val("idle_hex", hex_word(), 16'h0000);
    $display("txn reset/idle done");

    // Single requester latency and live data update
    bus.req = 4'b0010;
    tick();
    check_val("r1_gnt", 16'(bus.gnt), 16'h0002);
    check_val("r1_busy", 16'(bus.busy), 16'h1);
    tick();
    check_val("r1_hex", hex_word(), 16'h1234);
    bus.data1 = 16'hABCD;
    tick();
    check_val("r1_hex_live", hex_word(), 16'hABCD);
    bus.req = 4'b0000;
    tick();
    check_val("r1_rel_gnt", 16'(bus.gnt), 16'h0);
    check_val("r1_rel_hex_lag", hex_word(), 16'hABCD);
    tick();
    check_val("r1_rel_hex_idle", hex_word(), 16'h0000);
    $display("txn single requester done");

    // Two requesters alternate every 8 cycles; last owner was 1, so 2 goes first
    bus.req   = 4'b0101;
    prev_data = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      tick();
      exp_gnt = (((k / 8) % 2) == 0) ? 4'b0100 : 4'b0001;
      check_val($sformatf("alt_gnt_%0d", k), 16'(bus.gnt), 16'(exp_gnt));
      check_val($sformatf("alt_hex_%0d", k), hex_word(), prev_data);
      prev_data = (exp_gnt == 4'b0100) ? 16'h2222 : 16'h1111;
    end
    bus.req = 4'b0000;
    tick();
    check_val("alt_rel_gnt", 16'(bus.gnt), 16'h0);
    tick();
    $display("txn alternation done");

    // Owner 2 drops at hold cycle 3 while 3 is pending
    bus.req = 4'b0100;
    tick();
    check_val("drop_g2", 16'(bus.gnt), 16'h0004);
    bus.req = 4'b1100;
    tick(); tick(); tick();
    check_val("drop_g2_hold", 16'(bus.gnt), 16'h0004);
    bus.req = 4'b1000;
    tick();
    check_val("drop_to3", 16'(bus.gnt), 16'h0008);
    bus.req = 4'b1100;
    for (int k = 1; k < 8; k++) begin
      tick();
      check_val($sformatf("hold3_%0d", k), 16'(bus.gnt), 16'h0008);
    end
    tick();
    check_val("hold3_rot", 16'(bus.gnt), 16'h0004);
    $display("txn drop with pending done");

    // Asynchronous reset mid-hold
    tick(); tick();
    check_val("prerst_gnt", 16'(bus.gnt), 16'h0004);
    check_val("prerst_hex", hex_word(), 16'h2222);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_gnt", 16'(bus.gnt), 16'h0);
    check_val("midrst_busy", 16'(bus.busy), 16'h0);
    check_val("midrst_hex", hex_word(), 16'h0000);
    tick();
    reset   = 1'b0;
    bus.req = 4'b1111;
    tick();
    check_val("postrst_gnt", 16'(bus.gnt), 16'h0001);
    tick();
    check_val("postrst_hex", hex_word(), 16'h1111);
    $display("txn mid-hold reset done");

    // Requester 0 rises while 3 owns at hold cycle 2
    bus.req = 4'b1000;
    tick();
    check_val("pre_g3", 16'(bus.gnt), 16'h0008);
    tick(); tick();
    check_val("pre_g3_hold", 16'(bus.gnt), 16'h0008);
    bus.req = 4'b1001;
    tick();
`ifdef SEG_ARB_PRIO_EN
    check_val("prio_g0", 16'(bus.gnt), 16'h0001);
    tick();
    check_val("prio_g0_keep", 16'(bus.gnt), 16'h0001);
`else
    check_val("noprio_g3", 16'(bus.gnt), 16'h0008);
    for (int k = 4; k < 8; k++) begin
      tick();
      check_val($sformatf("noprio_hold_%0d", k), 16'(bus.gnt), 16'h0008);
    end
    tick();
    check_val("noprio_rot_g0", 16'(bus.gnt), 16'h0001);
`endif
    $display("txn req0 arrival done");

    exp_hex = hex_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_share_arb.md
Name: seg_share_arb

Overview:
- Round-robin arbiter that shares the single 4-digit seven-segment display driver among 4 requesters.
- Each requester presents a 16-bit hex word (4 nibbles).
- The arbiter grants ownership with a minimum hold time and registers the owner's word onto the driver's hex3..hex0 inputs.
- Sits between application blocks (counters, status, debug) and the display scan/decode driver.

Parameters:
- HOLD_CYC, 8, minimum cycles an owner keeps the display before it can be rotated away (must be >=1).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYC.
- IDLE_WORD, 16'h0000, word driven on hex3..hex0 while no requester owns the display.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  level request per requester; bit i = requester i.
- data0  input  16  requester 0 word; [15:12]->hex3 ... [3:0]->hex0.
- data1  input  16  requester 1 word.
- data2  input  16  requester 2 word.
- data3  input  16  requester 3 word.
- gnt  output  4  one-hot grant; all-zero when idle.
- busy  output  1  1 while any grant is active.
- hex3  output  4  digit 3 nibble to display driver.
- hex2  output  4  digit 2 nibble.
- hex1  output  4  digit 1 nibble.
- hex0  output  4  digit 0 nibble.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, gnt=0, busy=0, hold counter=0, last-owner pointer=3 (so requester 0 wins first), {hex3..hex0}=IDLE_WORD.
- Round-robin search starts at (last_owner+1) mod 4 and wraps to find the first set req bit. last_owner updates on every new grant.
- States:
  - IDLE: if req!=0, grant the RR winner next cycle -> HOLD; counter cleared.
  - HOLD: counter increments each cycle. If the owner drops req -> release (see below). When counter reaches HOLD_CYC-1 -> OPEN.
  - OPEN: owner keeps the grant while no other req bit is set. If another req bit is set and the owner still requests, rotate to the RR winner among others next cycle -> HOLD, counter cleared. If the owner drops req -> release.
  - Release: if other requests are pending, grant the RR winner directly next cycle (HOLD, counter cleared); else -> IDLE, gnt=0.
- Latency: req rising at cycle n -> gnt and busy valid at n+1 -> hex shows the owner's data sampled at n+1 on cycle n+2.
- Hex outputs: registered every cycle from the current owner's dataN. While the grant holds, live updates pass with 1-cycle lag. When idle, IDLE_WORD is loaded one cycle after gnt clears.
- gnt is always one-hot or zero. No cycle has two bits set. A switch moves directly from owner A to owner B with no gap cycle.
- Owner req deasserted in the same cycle the counter expires: release takes precedence over the OPEN transition.
- req bits for non-owners can toggle freely and never affect the current hold.
- Reset mid-grant: immediate return to reset values; no hex word is retained.
- Counter saturates conceptually at HOLD_CYC-1. It never wraps within HOLD.

Optional Feature:
- Macro: SEG_ARB_PRIO_EN.
- Defined: requester 0 is urgent. If req[0] rises while another requester owns the display (HOLD or OPEN), the grant moves to requester 0 on the next cycle regardless of the hold counter, and the counter is cleared. Requester 0's own hold is still subject to the normal rotation rules. last_owner is set to 0.
- Undefined: requester 0 is a normal round-robin participant; the logic is not built.

Test Plan:
- Reset then req=4'b0000 -> gnt=0, busy=0, {hex3..hex0}=16'h0000 indefinitely.
- req=4'b0010, data1=16'h1234 at cycle 0 -> gnt=4'b0010 at cycle 1, hex3..hex0=1,2,3,4 at cycle 2. Change data1 to 16'hABCD -> hex shows A,B,C,D one cycle later.
- req=4'b0101 held, HOLD_CYC=8 -> gnt alternates 0001, 0100, 0001, ..., each owner exactly 8 cycles (HOLD_CYC) with no gap and no overlap.
- Owner 2 drops req at hold cycle 3 with req[3] pending -> gnt=4'b1000 next cycle, counter restarts. With nothing pending -> gnt=0 and hex=IDLE_WORD one cycle after.
- Assert reset for 1 cycle mid-HOLD with gnt=4'b0100 -> gnt=0 and hex=0000 immediately; after release, req=4'b1111 grants requester 0 first.
- With SEG_ARB_PRIO_EN defined, requester 3 owns at hold cycle 2 and req[0] rises -> gnt=4'b0001 on the next cycle. Without the macro, requester 3 keeps the grant until HOLD_CYC expires.
